// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: common data bus record and CDB source indices.
package rv32i_types;

  localparam int unsigned CDB_ROB_IDX_WIDTH = 5;
  localparam int unsigned CDB_NUM_FU        = 3;
  localparam int unsigned CDB_FIFO_DEPTH    = 2;

  localparam int unsigned FU_ALU    = 0;
  localparam int unsigned FU_MULDIV = 1;
  localparam int unsigned FU_LSU    = 2;

  typedef struct packed {
    logic                         valid;
    logic [31:0]                  data;
    logic [4:0]                   rd_addr;
    logic [CDB_ROB_IDX_WIDTH-1:0] rob_idx;
  } cdb;

endpackage

// File: rtl/cdb_result_fifo.sv
// Small per-source result FIFO with wrap-bit pointers and a synchronous flush.
module cdb_result_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrWidth = $clog2(DEPTH) + 1;

  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                do_push, do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {(PtrWidth-1){1'b0}}};
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem_q[rd_ptr_q[PtrWidth-2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrWidth-2:0]] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit side: buffers functional-unit results and broadcasts one per cycle,
// round-robin across sources, on a registered bus.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NUM_FU     = CDB_NUM_FU,
  parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NUM_FU-1:0] fu_valid,
  output logic [NUM_FU-1:0] fu_ready,
  input  cdb                fu_result [NUM_FU],
  output cdb                cdbus
);

  localparam int unsigned RrWidth = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [RrWidth-1:0] rr_ptr_q, rr_ptr_d, grant_idx;
  logic               grant_valid;
  logic [NUM_FU-1:0]  fifo_full, fifo_empty, fifo_push, fifo_pop;
  cdb                 fifo_head [NUM_FU];
  cdb                 cdbus_d, cdbus_q;

  // Ready deliberately ignores a same-cycle pop to keep it off the arbiter path.
  assign fu_ready  = ~fifo_full & {NUM_FU{~flush}};
  assign fifo_push = fu_valid & fu_ready;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    cdb_result_fifo #(
      .WIDTH ($bits(cdb)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (fifo_push[i]),
      .din   (fu_result[i]),
      .pop   (fifo_pop[i]),
      .dout  (fifo_head[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i])
    );
  end

  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_FU;
      if (!grant_valid && !fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = RrWidth'(idx);
      end
    end
  end

  always_comb begin
    fifo_pop = '0;
    cdbus_d  = '0;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (grant_valid) begin
      fifo_pop[grant_idx] = 1'b1;
      cdbus_d             = fifo_head[grant_idx];
      cdbus_d.valid       = 1'b1;
      rr_ptr_d            = (grant_idx == RrWidth'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cdbus_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdbus_q  <= cdbus_d;
    end
  end

  assign cdbus = cdbus_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with hand-computed cycle tables.
module tb_cdb_arbiter;
  import rv32i_types::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] fu_valid;
  logic [2:0] fu_ready;
  cdb         fu_result [CDB_NUM_FU];
  cdb         cdbus;

  int n_cmp = 0;
  int n_err = 0;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_ready  (fu_ready),
    .fu_result (fu_result),
    .cdbus     (cdbus)
  );

  always #5 clk = ~clk;

  function automatic cdb mk(input logic [4:0] rob);
    cdb r;
    r.valid   = 1'b0;
    r.data    = {16'hC0DE, 11'd0, rob};
    r.rd_addr = ~rob;
    r.rob_idx = rob;
    return r;
  endfunction

  function automatic cdb bcast(input int rob);
    cdb r;
    if (rob < 0) begin
      r = '0;
    end else begin
      r       = mk(5'(rob));
      r.valid = 1'b1;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (cdbus !== '0) begin
      n_err++;
      $display("FAIL reset_cdbus: got %h expected %h", cdbus, cdb'('0));
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (fu_ready !== 3'b111) begin
      n_err++;
      $display("FAIL reset_ready: got %b expected %b", fu_ready, 3'b111);
    end
    step();
  endtask

  task automatic test_contention();
    int exp_rob [9];
    cdb e;
    exp_rob = '{-1, -1, 10, 11, 12, 13, 14, 15, -1};
    for (int cyc = 0; cyc < 9; cyc++) begin
      fu_valid = (cyc == 0 || cyc == 3) ? 3'b111 : 3'b000;
      for (int s = 0; s < 3; s++) fu_result[s] = mk(5'(10 + s + ((cyc == 3) ? 3 : 0)));
      #1;
      if (cyc == 0 || cyc == 3) begin
        n_cmp++;
        if (fu_ready !== 3'b111) begin
          n_err++;
          $display("FAIL cont_ready cyc %0d: got %b expected %b", cyc, fu_ready, 3'b111);
        end
      end
      e = bcast(exp_rob[cyc]);
      n_cmp++;
      if (cdbus !== e) begin
        n_err++;
        $display("FAIL cont_cdbus cyc %0d: got %h expected %h", cyc, cdbus, e);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_rdy [6];
    int exp_rob [13];
    int base [3];
    int cnt [3];
    cdb e;
    exp_rdy = '{3'b111, 3'b111, 3'b001, 3'b010, 3'b100, 3'b001};
    exp_rob = '{-1, -1, 0, 8, 16, 1, 9, 17, 2, 10, 18, 3, -1};
    base    = '{0, 8, 16};
    cnt     = '{0, 0, 0};
    for (int cyc = 0; cyc < 13; cyc++) begin
      fu_valid = {cyc <= 5, cyc <= 3, cyc <= 5};
      for (int s = 0; s < 3; s++) fu_result[s] = mk(5'(base[s] + cnt[s]));
      #1;
      if (cyc < 6) begin
        n_cmp++;
        if (fu_ready !== exp_rdy[cyc]) begin
          n_err++;
          $display("FAIL bp_ready cyc %0d: got %b expected %b", cyc, fu_ready, exp_rdy[cyc]);
        end
        for (int s = 0; s < 3; s++) if (fu_valid[s] && exp_rdy[cyc][s]) cnt[s]++;
      end
      e = bcast(exp_rob[cyc]);
      n_cmp++;
      if (cdbus !== e) begin
        n_err++;
        $display("FAIL bp_cdbus cyc %0d: got %h expected %h", cyc, cdbus, e);
      end
      step();
    end
    fu_valid = 3'b000;
  endtask

  task automatic test_fairness();
    logic [2:0] exp_rdy [8];
    int exp_rob [13];
    int base [2];
    int cnt [2];
    cdb e;
    exp_rdy = '{3'b111, 3'b111, 3'b110, 3'b101, 3'b110, 3'b101, 3'b110, 3'b101};
    exp_rob = '{-1, -1, 25, 20, 26, 21, 27, 22, 28, 23, 29, 24, -1};
    base    = '{20, 25};
    cnt     = '{0, 0};
    for (int cyc = 0; cyc < 13; cyc++) begin
      fu_valid = {1'b0, cyc <= 7, cyc <= 7};
      for (int s = 0; s < 2; s++) fu_result[s] = mk(5'(base[s] + cnt[s]));
      fu_result[2] = mk(5'd31);
      #1;
      if (cyc < 8) begin
        n_cmp++;
        if (fu_ready !== exp_rdy[cyc]) begin
          n_err++;
          $display("FAIL fair_ready cyc %0d: got %b expected %b", cyc, fu_ready, exp_rdy[cyc]);
        end
        for (int s = 0; s < 2; s++) if (fu_valid[s] && exp_rdy[cyc][s]) cnt[s]++;
      end
      e = bcast(exp_rob[cyc]);
      n_cmp++;
      if (cdbus !== e) begin
        n_err++;
        $display("FAIL fair_cdbus cyc %0d: got %h expected %h", cyc, cdbus, e);
      end
      step();
    end
    fu_valid = 3'b000;
  endtask

  task automatic test_single();
    cdb in_r, e;
    in_r.valid   = 1'b0;
    in_r.data    = 32'hDEAD_BEEF;
    in_r.rd_addr = 5'd5;
    in_r.rob_idx = 5'd3;
    e            = in_r;
    e.valid      = 1'b1;
    fu_result[0] = in_r;
    fu_valid     = 3'b001;
    step();
    fu_valid = 3'b000;
    n_cmp++;
    if (cdbus.valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_c1: got valid %b expected %b", cdbus.valid, 1'b0);
    end
    step();
    n_cmp++;
    if (cdbus !== e) begin
      n_err++;
      $display("FAIL single_c2: got %h expected %h", cdbus, e);
    end
    step();
    n_cmp++;
    if (cdbus !== '0) begin
      n_err++;
      $display("FAIL single_c3: got %h expected %h", cdbus, cdb'('0));
    end
  endtask

  task automatic test_flush();
    cdb e;
    for (int s = 0; s < 3; s++) fu_result[s] = mk(5'(1 + s));
    fu_valid = 3'b111;
    step();
    fu_result[0] = mk(5'd4);
    fu_result[1] = mk(5'd5);
    fu_valid     = 3'b011;
    step();
    for (int s = 0; s < 3; s++) fu_result[s] = mk(5'(6 + s));
    fu_valid = 3'b111;
    flush    = 1'b1;
    #1;
    n_cmp++;
    if (fu_ready !== 3'b000) begin
      n_err++;
      $display("FAIL flush_ready: got %b expected %b", fu_ready, 3'b000);
    end
    e = bcast(2);
    n_cmp++;
    if (cdbus !== e) begin
      n_err++;
      $display("FAIL flush_pre: got %h expected %h", cdbus, e);
    end
    step();
    flush        = 1'b0;
    fu_result[1] = mk(5'd30);
    fu_result[2] = mk(5'd31);
    fu_valid     = 3'b110;
    #1;
    n_cmp++;
    if (fu_ready !== 3'b111) begin
      n_err++;
      $display("FAIL flush_ready_after: got %b expected %b", fu_ready, 3'b111);
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      case (cyc)
        2:       e = bcast(30);
        3:       e = bcast(31);
        default: e = '0;
      endcase
      n_cmp++;
      if (cdbus !== e) begin
        n_err++;
        $display("FAIL flush_cdbus cyc %0d: got %h expected %h", cyc, cdbus, e);
      end
      step();
      fu_valid = 3'b000;
    end
  endtask

  task automatic test_async_reset();
    cdb e;
    for (int s = 0; s < 3; s++) fu_result[s] = mk(5'(11 + s));
    fu_valid = 3'b111;
    step();
    fu_valid = 3'b000;
    step();
    e = bcast(11);
    n_cmp++;
    if (cdbus !== e) begin
      n_err++;
      $display("FAIL arst_pre: got %h expected %h", cdbus, e);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (cdbus !== '0) begin
      n_err++;
      $display("FAIL arst_now: got %h expected %h", cdbus, cdb'('0));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (fu_ready !== 3'b111) begin
      n_err++;
      $display("FAIL arst_ready: got %b expected %b", fu_ready, 3'b111);
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      step();
      n_cmp++;
      if (cdbus !== '0) begin
        n_err++;
        $display("FAIL arst_stale cyc %0d: got %h expected %h", cyc, cdbus, cdb'('0));
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    fu_valid = 3'b000;
    for (int s = 0; s < 3; s++) fu_result[s] = '0;
    test_reset();
    test_contention();
    test_backpressure();
    test_fairness();
    test_single();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
